imem_loader: RTL and testbench

Writer-side companion to the processor's instruction memory. Receives a byte stream over a valid/ready handshake, for example from a UART or debug bridge, and packs each group of bytes into an instruction word, little-endian. Writes each word into instruction memory at byte addresses that step by 4 (the PC convention). Holds the CPU while loading, then checks a trailing checksum byte and pulses done.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Packs a byte stream (valid/ready) into little-endian instruction words and
//   writes them to instruction memory at byte addresses stepping by BPW. The
//   CPU is held while a load runs. The load ends with a checksum byte, which is
//   the modulo-256 sum of all data bytes, and then a one-cycle done pulse.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, word_count : load request (honoured in IDLE only) and word count
//   byte_valid/ready  : byte stream handshake, byte_data is the payload
//   mem_we/addr/wdata : instruction memory write port (one-cycle writes)
//   busy, cpu_hold    : status and processor stall
//   done, error       : completion pulse and sticky checksum-mismatch flag
module imem_loader #(
  parameter int                     INS_ADDRESS = 32,
  parameter int                     INS_W       = 32,
  parameter int                     CNT_W       = 16,
  parameter logic [INS_ADDRESS-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       word_count,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_we,
  output logic [INS_ADDRESS-1:0] mem_addr,
  output logic [INS_W-1:0]       mem_wdata,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error
);

  localparam int BPW   = INS_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [INS_ADDRESS-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]             sum_q, sum_d;
  logic [CNT_W-1:0]       words_left_q, words_left_d;
  logic [INS_W-1:0]       word_q, word_d;
  logic                   byte_ready_q, byte_ready_d;
  logic                   mem_we_q, mem_we_d;
  logic [INS_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [INS_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                   busy_q, busy_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   xfer;
  logic [INS_W-1:0]       word_next;

  // byte_ready_q already reflects the current state, so it qualifies transfers.
  assign xfer = byte_valid & byte_ready_q;

  // Word with the incoming byte dropped into the lane selected by byte_idx.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    assign word_next[8*gi +: 8] = (byte_idx_q == IDX_W'(gi)) ? byte_data
                                                             : word_q[8*gi +: 8];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    sum_d        = sum_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    error_d      = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (word_count != '0) begin
            state_d      = S_RECV;
            addr_d       = BASE_ADDR;
            byte_idx_d   = '0;
            sum_d        = '0;
            words_left_d = word_count;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          sum_d  = sum_q + byte_data;
          word_d = word_next;
          if (byte_idx_q == LAST_IDX) begin
            // Write port is loaded here so it is valid throughout WRITE.
            state_d     = S_WRITE;
            mem_addr_d  = addr_q;
            mem_wdata_d = word_next;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      S_WRITE: begin
        addr_d       = addr_q + INS_ADDRESS'(BPW);
        words_left_d = words_left_q - CNT_W'(1);
        byte_idx_d   = '0;
        state_d      = (words_left_q == CNT_W'(1)) ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        if (xfer) begin
          error_d = (byte_data != sum_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    byte_ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
    mem_we_d     = (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    cpu_hold_d   = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      byte_idx_q   <= '0;
      sum_q        <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      sum_q        <= sum_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: two instances (default base address and a base
// near the top of the address space), randomized byte streams, and a
// reference model that derives expected writes and checksum from the stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        use_b;

  logic        start_a, start_b;
  logic        byte_ready_a, mem_we_a, busy_a, cpu_hold_a, done_a, error_a;
  logic        byte_ready_b, mem_we_b, busy_b, cpu_hold_b, done_b, error_b;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_addr_b, mem_wdata_b;

  assign start_a = start & ~use_b;
  assign start_b = start & use_b;

  imem_loader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .busy(busy_a), .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a)
  );

  imem_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .busy(busy_b), .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b)
  );

  always #5 clk = ~clk;

  // Outputs of whichever instance the current test drives.
  logic        sel_ready, sel_we, sel_busy, sel_hold, sel_done, sel_error;
  logic [31:0] sel_addr, sel_data;
  assign sel_ready = use_b ? byte_ready_b : byte_ready_a;
  assign sel_we    = use_b ? mem_we_b     : mem_we_a;
  assign sel_busy  = use_b ? busy_b       : busy_a;
  assign sel_hold  = use_b ? cpu_hold_b   : cpu_hold_a;
  assign sel_done  = use_b ? done_b       : done_a;
  assign sel_error = use_b ? error_b      : error_a;
  assign sel_addr  = use_b ? mem_addr_b   : mem_addr_a;
  assign sel_data  = use_b ? mem_wdata_b  : mem_wdata_a;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         wr_log[$];
  int          xfer_cnt;
  int          done_cnt;
  logic [7:0]  stim_q[$];
  bit          restart_pending = 1'b0;
  bit          toggle_phase = 1'b0;

  // Write monitor: logs every write and checks byte_ready is low in WRITE.
  always @(negedge clk) begin
    if (mem_we_a) begin
      wr_log.push_back('{mem_addr_a, mem_wdata_a});
      checks++;
      if (byte_ready_a !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write_a: byte_ready=%b required 0", byte_ready_a);
      end
    end
    if (mem_we_b) begin
      wr_log.push_back('{mem_addr_b, mem_wdata_b});
      checks++;
      if (byte_ready_b !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_write_b: byte_ready=%b required 0", byte_ready_b);
      end
    end
    if (done_a || done_b) done_cnt++;
  end

  always @(posedge clk) begin
    if (!rst && byte_valid && sel_ready) xfer_cnt++;
  end

  // Offers one byte until it is accepted; returns just after the accepting edge.
  // mode 0: valid always high, 1: random gaps, 2: toggles every other cycle
  // but stays high while the loader is writing.
  task automatic send_byte(input logic [7:0] b, input int mode);
    for (int budget = 0; budget < 64; budget++) begin
      @(negedge clk);
      start = restart_pending;
      if (restart_pending) word_count = 16'd7;
      restart_pending = 1'b0;
      checks++;
      if (sel_hold !== 1'b1) begin
        errors++;
        $display("FAIL cpu_hold_during_load: got %b required 1", sel_hold);
      end
      if (mode == 0) begin
        byte_valid = 1'b1;
      end else if (byte_valid && !sel_ready) begin
        byte_valid = 1'b1;
      end else if (mode == 1) begin
        byte_valid = ($urandom_range(0, 2) != 0);
      end else if (sel_we) begin
        byte_valid = 1'b1;
      end else begin
        toggle_phase = !toggle_phase;
        byte_valid = toggle_phase;
      end
      byte_data = byte_valid ? b : 8'($urandom);
      if (byte_valid && sel_ready) begin
        @(posedge clk);
        return;
      end
    end
    errors++;
    $display("FAIL byte_accept_timeout: byte %02h not accepted in 64 cycles", b);
  endtask

  // Runs a full load from stim_q (random if empty) and checks it against the model.
  task automatic do_load(input string name, input int wc, input int mode,
                         input bit corrupt, input logic [31:0] base, input int restart_at);
    logic [7:0]  sum;
    logic [7:0]  cks;
    logic [31:0] w;
    wr_t         exp_q[$];
    if (stim_q.size() == 0)
      for (int i = 0; i < 4 * wc; i++) stim_q.push_back(8'($urandom));
    sum = 8'h00;
    foreach (stim_q[i]) sum = sum + stim_q[i];
    for (int wi = 0; wi < wc; wi++) begin
      w = {stim_q[4*wi+3], stim_q[4*wi+2], stim_q[4*wi+1], stim_q[4*wi]};
      exp_q.push_back('{base + 32'(4 * wi), w});
    end
    cks = corrupt ? sum + 8'd1 : sum;
    wr_log.delete();
    xfer_cnt = 0;
    done_cnt = 0;

    @(negedge clk);
    word_count = 16'(wc);
    start = 1'b1;
    foreach (stim_q[i]) begin
      if (i == restart_at) restart_pending = 1'b1;
      send_byte(stim_q[i], mode);
    end
    send_byte(cks, mode);

    @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (sel_done !== 1'b1 || sel_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_cycle: done=%b cpu_hold=%b required 1 1", name, sel_done, sel_hold);
    end
    checks++;
    if (sel_error !== corrupt) begin
      errors++;
      $display("FAIL %s_error: got %b required %b", name, sel_error, corrupt);
    end
    @(negedge clk);
    checks++;
    if (sel_done !== 1'b0 || sel_busy !== 1'b0 || sel_hold !== 1'b0 ||
        sel_ready !== 1'b0 || sel_error !== corrupt) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b hold=%b ready=%b error=%b required 0 0 0 0 %b",
               name, sel_done, sel_busy, sel_hold, sel_ready, sel_error, corrupt);
    end
    checks++;
    if (wr_log.size() != wc) begin
      errors++;
      $display("FAIL %s_write_count: got %0d required %0d", name, wr_log.size(), wc);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) begin
          errors++;
          $display("FAIL %s_write%0d: got (%08h,%08h) required (%08h,%08h)", name, i,
                   wr_log[i].addr, wr_log[i].data, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
    checks++;
    if (xfer_cnt != 4 * wc + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL %s_transfers: bytes=%0d dones=%0d required %0d 1", name, xfer_cnt,
               done_cnt, 4 * wc + 1);
    end
    $display("load %s: words=%0d mode=%0d checksum=%02h error=%b", name, wc, mode, cks, sel_error);
    stim_q.delete();
  endtask

  task automatic set_nominal_stream();
    stim_q = '{8'h93, 8'h00, 8'h20, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    word_count = 16'd0; use_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready_a, mem_we_a, busy_a, cpu_hold_a, done_a, error_a} !== 6'b0 ||
        mem_addr_a !== 32'h0 || mem_wdata_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready/we/busy/hold/done/err=%b addr=%08h data=%08h required zeros",
               {byte_ready_a, mem_we_a, busy_a, cpu_hold_a, done_a, error_a}, mem_addr_a, mem_wdata_a);
    end
    $display("reset: outputs sampled after reset release");
  endtask

  task automatic test_nominal();
    set_nominal_stream();
    do_load("nominal", 2, 0, 1'b0, 32'h0, -1);
  endtask

  task automatic test_zero_count(input bit expect_prior_error);
    wr_log.delete();
    @(negedge clk);
    checks++;
    if (sel_error !== expect_prior_error) begin
      errors++;
      $display("FAIL zero_prior_error: got %b required %b", sel_error, expect_prior_error);
    end
    word_count = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (sel_done !== 1'b1 || sel_error !== 1'b0 || sel_hold !== 1'b1) begin
      errors++;
      $display("FAIL zero_count_done: done=%b error=%b hold=%b required 1 0 1", sel_done, sel_error, sel_hold);
    end
    @(negedge clk);
    checks++;
    if (sel_done !== 1'b0 || sel_busy !== 1'b0 || wr_log.size() != 0) begin
      errors++;
      $display("FAIL zero_count_after: done=%b busy=%b writes=%0d required 0 0 0", sel_done, sel_busy, wr_log.size());
    end
    $display("load zero_count: words=0 error cleared");
  endtask

  task automatic test_bad_checksum();
    set_nominal_stream();
    do_load("bad_checksum", 2, 0, 1'b1, 32'h0, -1);
    repeat (3) @(negedge clk);
    checks++;
    if (sel_error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: got %b required 1", sel_error);
    end
    test_zero_count(1'b1);
  endtask

  task automatic test_stalls();
    set_nominal_stream();
    do_load("stalls", 2, 2, 1'b0, 32'h0, -1);
  endtask

  task automatic test_reset_mid_load();
    wr_log.delete();
    done_cnt = 0;
    @(negedge clk);
    word_count = 16'd2;
    start = 1'b1;
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({byte_ready_a, mem_we_a, busy_a, cpu_hold_a, done_a, error_a} !== 6'b0 ||
        mem_addr_a !== 32'h0 || mem_wdata_a !== 32'h0) begin
      errors++;
      $display("FAIL midload_reset_outputs: ready/we/busy/hold/done/err=%b addr=%08h data=%08h required zeros",
               {byte_ready_a, mem_we_a, busy_a, cpu_hold_a, done_a, error_a}, mem_addr_a, mem_wdata_a);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_log.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL midload_abandoned: writes=%0d dones=%0d required 0 0", wr_log.size(), done_cnt);
    end
    $display("reset mid-load: load abandoned");
    stim_q = '{8'h93, 8'h00, 8'h20, 8'h00};
    do_load("reload", 1, 0, 1'b0, 32'h0, -1);
  endtask

  task automatic test_restart_ignored();
    do_load("restart_ignored", 2, 0, 1'b0, 32'h0, 2);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++)
      do_load("random", $urandom_range(1, 4), 1, 1'($urandom_range(0, 1)), 32'h0, -1);
  endtask

  task automatic test_addr_wrap();
    use_b = 1'b1;
    do_load("addr_wrap", 2, 1, 1'b0, 32'hFFFF_FFFC, -1);
    use_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_stalls();
    test_reset_mid_load();
    test_zero_count(1'b0);
    test_restart_ignored();
    test_back_to_back();
    test_addr_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
